// File: rtl/mc_datapath_pkg.sv
// rtl/mc_datapath_pkg.sv - shared state encoding, ALU op codes and control word for mc_datapath
package mc_datapath_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DEC  = 3'd1,
    EXE  = 3'd2,
    MEM  = 3'd3,
    WB   = 3'd4
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic       regwrite;
    logic       regdst;
    logic       extop;
    logic       alusrc;
    logic       memwrite;
    logic       memread;
    logic       mem2reg;
    logic       shiftctrl;
    logic [3:0] aluctrl;
  } ctrl_t;

endpackage

// File: rtl/mc_datapath_alu.sv
// rtl/mc_datapath_alu.sv - combinational WIDTH-bit ALU (alu_n) used in the EXE state
module alu_n
  import mc_datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] y
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_NOR: y = ~(a | b);
      ALU_SLT: y = WIDTH'($signed(a) < $signed(b));
      ALU_SLL: y = a << sh;
      ALU_SRL: y = a >> sh;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mc_datapath.sv
// rtl/mc_datapath.sv - multi-cycle MIPS-style datapath with latency-tolerant data memory port
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic             regwrite,
  input  logic             regdst,
  input  logic             extop,
  input  logic             alusrc,
  input  logic             memwrite,
  input  logic             memread,
  input  logic             mem2reg,
  input  logic             shiftctrl,
  input  logic [3:0]       aluctrl,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             zero,
  output logic             msb,
  output logic [WIDTH-1:0] regout,
  output logic [WIDTH-1:0] write,
  output logic             done
);

  localparam int RW = $clog2(NREGS);

  state_t           state_q, state_d;
  logic [31:0]      inst_q, inst_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [WIDTH-1:0] alu_q, alu_d, mdr_q, mdr_d;
  logic             zero_q, zero_d, msb_q, msb_d;

  logic [RW-1:0]    rs_idx, rt_idx, rd_idx, wb_idx;
  logic [WIDTH-1:0] rs_val, rt_val, op_b, alu_y;
  logic             unused_opcode;

  assign unused_opcode = ^inst_q[31:26];

  assign rs_idx = inst_q[21 +: RW];
  assign rt_idx = inst_q[16 +: RW];
  assign rd_idx = inst_q[11 +: RW];
  assign wb_idx = ctrl_q.regdst ? rd_idx : rt_idx;

  // R0 is never written, but the read is forced too so it cannot depend on that.
  assign rs_val = (rs_idx == '0) ? '0 : regs_q[rs_idx];
  assign rt_val = (rt_idx == '0) ? '0 : regs_q[rt_idx];

  assign op_b = ctrl_q.shiftctrl ? WIDTH'(inst_q[10:6]) :
                (ctrl_q.alusrc ? imm_q : b_q);

  alu_n #(.WIDTH(WIDTH)) u_alu (
    .a  (a_q),
    .b  (op_b),
    .op (ctrl_q.aluctrl),
    .y  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    ctrl_d  = ctrl_q;
    regs_d  = regs_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    zero_d  = zero_q;
    msb_d   = msb_q;
    case (state_q)
      IDLE: begin
        if (inst_valid) begin
          inst_d  = inst;
          ctrl_d  = {regwrite, regdst, extop, alusrc, memwrite, memread,
                     mem2reg, shiftctrl, aluctrl};
          state_d = DEC;
        end
      end
      DEC: begin
        a_d     = ctrl_q.shiftctrl ? rt_val : rs_val;
        b_d     = rt_val;
        imm_d   = ctrl_q.extop ? WIDTH'($signed(inst_q[15:0])) : WIDTH'(inst_q[15:0]);
        state_d = EXE;
      end
      EXE: begin
        alu_d   = alu_y;
        zero_d  = (alu_y == '0);
        msb_d   = alu_y[WIDTH-1];
        state_d = (ctrl_q.memread || ctrl_q.memwrite) ? MEM : WB;
      end
      MEM: begin
        if (dmem_ack) begin
          // A write wins when both memread and memwrite are set.
          if (ctrl_q.memread && !ctrl_q.memwrite) mdr_d = dmem_rdata;
          state_d = WB;
        end
      end
      WB: begin
        if (ctrl_q.regwrite && (wb_idx != '0))
          regs_d[wb_idx] = ctrl_q.mem2reg ? mdr_q : alu_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      inst_q  <= '0;
      ctrl_q  <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      zero_q  <= 1'b0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      ctrl_q  <= ctrl_d;
      regs_q  <= regs_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      zero_q  <= zero_d;
      msb_q   <= msb_d;
    end
  end

  assign inst_ready = (state_q == IDLE);
  assign dmem_req   = (state_q == MEM);
  assign dmem_we    = ctrl_q.memwrite;
  assign dmem_addr  = alu_q;
  assign dmem_wdata = b_q;
  assign zero       = zero_q;
  assign msb        = msb_q;
  assign regout     = a_q;
  assign write      = mdr_q;
  assign done       = (state_q == WB) && !rst;

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Parametrised multi-cycle successor to the single-cycle processor datapath. It accepts one 32-bit MIPS-format instruction plus its decoded control word through a valid/ready handshake. It then steps the instruction through decode, execute, memory and write-back states. Data memory is external, reached over a request/acknowledge port that tolerates any latency. The block sits between the control unit (the instruction/control source) and a data memory of arbitrary latency.

## Interface
- WIDTH, 32, datapath/register width; legal range 16..64
- NREGS, 32, register count; power of two, 2..32; register index = low log2(NREGS) bits of the rs/rt/rd fields
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- inst  in  32  instruction (rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], imm=[15:0])
- inst_valid  in  1  inst and control inputs valid
- inst_ready  out  1  block can accept an instruction
- regwrite, regdst, extop, alusrc, memwrite, memread, mem2reg, shiftctrl  in  1 each  decoded controls, same meanings as the single-cycle datapath; memread is new
- aluctrl  in  4  ALU op
- dmem_req  out  1  memory access request
- dmem_we  out  1  1 = write
- dmem_addr  out  WIDTH  ALU result
- dmem_wdata  out  WIDTH  rt value
- dmem_ack  in  1  access complete; rdata valid when !we
- dmem_rdata  in  WIDTH  read data
- zero, msb  out  1 each  ALU result == 0 / ALU result MSB, registered
- regout  out  WIDTH  latched operand A
- write  out  WIDTH  last memory read data, registered
- done  out  1  one-cycle pulse when an instruction retires

## Operation
- FSM states: IDLE, DEC, EXE, MEM, WB.
- IDLE: inst_ready=1. On inst_valid, latch inst and all controls, then go to DEC.
- DEC: read the register file into A and B.
  - A = R[rt] if shiftctrl, else R[rs].
  - B = R[rt].
  - Latch the extended immediate: sign-extended if extop, else zero-extended to WIDTH.
  - Go to EXE.
- EXE: second operand = shamt zero-extended if shiftctrl, else (imm if alusrc, else B).
  - Latch ALUOut, zero and msb.
  - Go to MEM if memread|memwrite, else WB.
- MEM: assert dmem_req, with dmem_we=memwrite, addr=ALUOut, wdata=B.
  - Hold all four stable until dmem_ack.
  - On ack: if read, latch MDR and write; go to WB.
- WB: if regwrite, write R[regdst ? rd : rt] = mem2reg ? MDR : ALUOut. Pulse done. Go to IDLE.
- R0 always reads 0; writes to R0 are ignored. This is new behaviour.
- memread and memwrite both set: treat as write only; MDR is not updated.
- ALU ops, arithmetic modulo 2^WIDTH:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR.
  - 0111 SLT: signed; result 1 or 0.
  - 0011 SLL, 0100 SRL: shift A by the low log2(WIDTH) bits of the second operand.
  - Other codes produce 0.
- Reset values: state IDLE; every register R0..R(NREGS-1), A, B, ALUOut, MDR and write = 0; zero=0, msb=0, done=0, dmem_req=0, inst_ready=1 in the cycle after rst.

## Timing
- Accept edge = edge where inst_valid && inst_ready.
- Non-memory instruction: states DEC, EXE, WB occupy the 3 cycles after the accept edge. done is high in cycle 3. inst_ready is high again in cycle 4. Throughput is 1 instruction per 4 cycles.
- Memory instruction: MEM lasts at least 1 cycle. An ack in the first MEM cycle gives done in cycle 4. Each additional wait cycle adds 1.
- The register write commits at the edge that ends WB. The next instruction's DEC observes it, so no hazard exists.
- dmem_ack outside MEM is ignored.
- rst mid-instruction: go to IDLE next cycle, drop dmem_req, do not write the register file, do not pulse done. The in-flight instruction is discarded.
- zero/msb/regout/write hold between updates.

## Structure
- Package mc_datapath_pkg: state encoding (IDLE..WB) and ALU op constants (ALU_AND … ALU_NOR).
- Sub-module alu_n #(WIDTH): combinational ALU with ops per the list above. Instantiated once.
- Register file inline: NREGS×WIDTH flops, one write port, two read ports, R0 forced to zero.

## Test plan
- Reset, then ADD: R1=5 and R2=7 preloaded via ADDI (alusrc, extop, ADD), then R3=R1+R2. Required: R3=12 via regout on a following op; done 3 cycles after each accept; zero=0.
- Signed immediate and SLT: ADDI R4=R0+0xFFFF with extop=1 → R4=all ones; SLT R5=R4<R1 → 1; msb=0 on that SLT. ANDI-style with extop=0 gives 0x0000FFFF.
- Memory with latency: SW R3 → addr 8, ack after 3 wait cycles; then LW R6 from 8 with ack immediate. Required: dmem_req held 4 then 1 cycles; R6=12; write=12; done at cycles 7 and 4.
- R0 and shift: write to R0 then read it → 0; SLL R7=R1<<4 (shiftctrl, shamt=4) → 80; SRL with WIDTH=16, shamt=17 → shift by 1.
- Reset in MEM: assert rst while dmem_req is pending. Required: req low next cycle, no done, destination register unchanged (0), inst_ready=1.
- Back-to-back: inst_valid held high continuously. Required: accept exactly every 4 cycles; a second instruction reading the prior destination gets the new value.
